// File: rtl/branch_imm_encoder.sv
// branch_imm_encoder: turns a branch target address into the 24-bit signed
// word-offset immediate of a B/BL instruction and emits the full instruction
// word. Two register stages advance together under a single stall condition.
// Range and alignment violations are flagged, and a saturating count of
// erroneous results is kept.
module branch_imm_encoder #(
  parameter logic [31:0] PC_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic [3:0]  cond,
  input  logic        link,
  input  logic        err_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] imm24,
  output logic [31:0] instr,
  output logic        range_err,
  output logic        align_err,
  output logic [7:0]  err_count
);

  logic        adv;
  logic        out_hs;

  logic        s1_valid;
  logic [31:0] s1_diff;
  logic [3:0]  s1_cond;
  logic        s1_link;

  logic        align_next;
  logic        range_next;
  logic [23:0] imm_next;

  // Both stages move only when the output slot is free or being drained, so
  // a stall freezes the whole pipe and the outputs hold stable.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_hs   = out_valid && out_ready;

  // Stage 1: capture the byte offset relative to the read-ahead PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_cond  <= '0;
      s1_link  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff <= target - (pc + PC_OFFSET);
        s1_cond <= cond;
        s1_link <= link;
      end
    end
  end

  // Range/alignment checks and immediate extraction from the stage-1 offset.
  always_comb begin
    align_next = (s1_diff[1:0] != 2'b00);
    range_next = (s1_diff[31:25] != {7{s1_diff[25]}});
    imm_next   = '0;
    if (!align_next && !range_next) begin
      imm_next = s1_diff[25:2];
    end
  end

  // Stage 2: registered result and instruction word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      imm24     <= '0;
      instr     <= '0;
      range_err <= 1'b0;
      align_err <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      imm24     <= imm_next;
      instr     <= {s1_cond, 3'b101, s1_link, imm_next};
      range_err <= range_next;
      align_err <= align_next;
    end
  end

  // Saturating error counter; a clear wins over a counted handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_hs && (range_err || align_err) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_branch_imm_encoder.sv
// Scoreboard bench for branch_imm_encoder: the driver pushes the expected
// result of each accepted request; an independent monitor pops and compares
// on every output handshake and tracks the error counter.
module tb_branch_imm_encoder;

  localparam logic [31:0] PC_OFF = 32'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0;
  logic [31:0] target = '0;
  logic [3:0]  cond = '0;
  logic        link = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] imm24;
  logic [31:0] instr;
  logic        range_err;
  logic        align_err;
  logic [7:0]  err_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] instr;
    logic [23:0] imm;
    logic        rerr;
    logic        aerr;
    logic        lat;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned err_model = 0;
  logic        rand_ready = 1'b0;
  logic        ready_force = 1'b1;
  logic        bp_done = 1'b0;

  branch_imm_encoder #(.PC_OFFSET(PC_OFF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .target(target), .cond(cond), .link(link), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .imm24(imm24), .instr(instr),
    .range_err(range_err), .align_err(align_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed word offset, legal when it fits 26 signed bits and is a
  // multiple of four.
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] t,
                                 input logic [3:0] c, input logic l);
    exp_t e;
    int   d;
    d      = int'(t - p - PC_OFF);
    e.pc   = p;
    e.target = t;
    e.aerr = (d % 4) != 0;
    e.rerr = (d < -33554432) || (d > 33554431);
    e.imm  = (e.aerr || e.rerr) ? 24'd0 : 24'(d / 4);
    e.instr = {c, 3'b101, l, e.imm};
    e.lat  = 1'b0;
    e.acc  = 0;
    return e;
  endfunction

  // Monitor: samples just before each rising edge.
  initial begin : monitor
    exp_t        e;
    logic        stall_prev;
    logic [31:0] h_instr;
    logic [23:0] h_imm;
    logic [1:0]  h_flags;
    logic        hs;
    logic        e_err;
    logic [31:0] back;
    stall_prev = 1'b0;
    h_instr = '0; h_imm = '0; h_flags = '0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        q.delete();
        err_model = 0;
        stall_prev = 1'b0;
        continue;
      end
      chk("err_count", {24'd0, err_count}, err_model);
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_instr", instr, h_instr);
        chk("hold_imm", {8'd0, imm24}, {8'd0, h_imm});
        chk("hold_flags", {30'd0, range_err, align_err}, {30'd0, h_flags});
      end
      hs = 1'b0;
      e_err = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got instr 0x%08h expected no result (cycle %0d)", instr, cyc);
          e_err = range_err || align_err;
          hs = out_ready;
        end else begin
          if (!stall_prev && q[0].lat) chk("latency", cyc - q[0].acc, 32'd2);
          if (out_ready) begin
            e = q.pop_front();
            hs = 1'b1;
            e_err = e.rerr || e.aerr;
            chk("imm24", {8'd0, imm24}, {8'd0, e.imm});
            chk("instr", instr, e.instr);
            chk("range_err", {31'd0, range_err}, {31'd0, e.rerr});
            chk("align_err", {31'd0, align_err}, {31'd0, e.aerr});
            if (!e.rerr && !e.aerr) begin
              back = {{6{imm24[23]}}, imm24, 2'b00} + e.pc + PC_OFF;
              chk("round_trip", back, e.target);
            end
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      h_instr = instr;
      h_imm = imm24;
      h_flags = {range_err, align_err};
      if (err_clr) err_model = 0;
      else if (hs && e_err && err_model != 255) err_model++;
    end
  end

  task automatic send(input logic [31:0] p, input logic [31:0] t,
                      input logic [3:0] c, input logic l);
    int unsigned n;
    exp_t e;
    n = 0;
    @(negedge clk); #1;
    in_valid = 1'b1; pc = p; target = t; cond = c; link = l;
    #2;
    while (!in_ready && n < 500) begin
      @(negedge clk); #3;
      n++;
    end
    if (in_ready) begin
      e = model(p, t, c, l);
      e.acc = cyc;
      e.lat = !rand_ready && ready_force;
      q.push_back(e);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1 within 500 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk); #4;
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", q.size());
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); #1; err_clr = 1'b1;
    @(negedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin : driver
    logic [31:0] d, p;
    int unsigned n;
    // Reset: in_ready must be high while held in reset.
    repeat (2) @(negedge clk);
    #3;
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd1);
    @(negedge clk); #1; rst_n = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_imm24", {8'd0, imm24}, 32'd0);
    chk("rst_flags", {30'd0, range_err, align_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed: forward, backward BL, range edge, range error.
    send(32'h100, 32'h200, 4'hE, 1'b0);
    send(32'h100, 32'h100, 4'hE, 1'b1);
    send(32'h0, 32'h0200_0004, 4'hE, 1'b0);
    send(32'h0, 32'h0200_0008, 4'hE, 1'b0);
    send(32'h0, 32'hFE00_0008, 4'h0, 1'b1);
    send(32'h0, 32'hFE00_0004, 4'h1, 1'b0);
    drain();
    @(negedge clk); #3;
    chk("err_count_after_range", {24'd0, err_count}, 32'd2);

    // Alignment errors until the counter saturates, then clear.
    for (int unsigned i = 0; i < 300; i++) begin
      send(32'h100, 32'h202, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    drain();
    @(negedge clk); #3;
    chk("err_count_saturated", {24'd0, err_count}, 32'h0000_00FF);
    pulse_clr();
    #2;
    chk("err_count_cleared", {24'd0, err_count}, 32'd0);

    // Backpressure: three requests against a stalled consumer.
    ready_force = 1'b0;
    idle(2);
    bp_done = 1'b0;
    fork
      begin
        send(32'h1000, 32'h2000, 4'hA, 1'b0);
        send(32'h1000, 32'h0F00, 4'hB, 1'b1);
        send(32'h1000, 32'h1003, 4'hC, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    #3;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    ready_force = 1'b1;
    n = 0;
    while (!bp_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bp_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: sends outstanding expected complete");
    end
    drain();

    // Randomized traffic with random consumer stalls.
    rand_ready = 1'b1;
    idle(1);
    for (int unsigned i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0: d = 32'($urandom_range(0, 2047)) * 32'd4 - 32'd4096;
        1: d = $urandom();
        2: d = 32'h0200_0000 + 32'($urandom_range(0, 16)) - 32'd8;
        default: d = 32'hFE00_0000 + 32'($urandom_range(0, 16)) - 32'd8;
      endcase
      p = $urandom();
      send(p, p + PC_OFF + d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) pulse_clr();
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    idle(1);
    drain();

    // Reset with two requests in flight.
    send(32'h400, 32'h800, 4'h3, 1'b0);
    send(32'h400, 32'h404, 4'h4, 1'b1);
    @(negedge clk); #1; rst_n = 1'b0;
    @(negedge clk); #1; rst_n = 1'b1;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err_count", {24'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(4);
    send(32'h2000, 32'h1000, 4'h5, 1'b1);
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
